aes_ctr_uart_serializer: RTL and testbench

Downstream stage of the pipelined AES-CTR core. It captures each 128-bit ciphertext block presented with a one-cycle valid pulse, buffers blocks in a small FIFO, and serializes each block into 16 bytes over a valid/ready byte interface to the UART transmitter. The AES core has no backpressure, so this block absorbs bursts and flags any dropped block.

---
 rtl/aes_uart_pkg.sv | 21 ++
 rtl/block_fifo.sv | 57 +++++
 rtl/aes_ctr_uart_serializer.sv | 96 +++++++++
 tb/tb_aes_ctr_uart_serializer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
// Shared types for the AES-CTR ciphertext-to-UART path: block/byte types,
// serializer states and the byte-shift helper.
package aes_uart_pkg;

  typedef logic [127:0] block_t;
  typedef logic [7:0]   byte_t;

  localparam int BYTES_PER_BLOCK = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } ser_state_t;

  // Drops the byte just sent so the next one sits in the output byte lane.
  function automatic block_t shift_byte(input block_t b, input bit msb_first);
    return msb_first ? {b[119:0], 8'h00} : {8'h00, b[127:8]};
  endfunction

endpackage

// File: rtl/block_fifo.sv
// DEPTH x 128-bit synchronous FIFO; a write while full is still accepted when
// a pop happens in the same cycle.
module block_fifo
  import aes_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [127:0]                 wr_data,
  input  logic                         rd_en,
  output logic [127:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  block_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aes_ctr_uart_serializer.sv
// Buffers 128-bit AES-CTR ciphertext blocks and serializes each into 16 bytes
// on a valid/ready interface; a sticky flag records any block dropped while full.
module aes_ctr_uart_serializer
  import aes_uart_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        blk_valid,
  input  logic [127:0]                blk_data,
  input  logic                        tx_ready,
  output logic                        tx_valid,
  output logic [7:0]                  tx_data,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  ser_state_t state;
  ser_state_t next_state;
  block_t     head;
  block_t     shreg;
  logic [3:0] byte_cnt;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fire;
  logic       last_byte;
  logic       drop;

  block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (blk_valid),
    .wr_data (blk_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign fire      = tx_valid && tx_ready;
  assign last_byte = fire && (byte_cnt == 4'(BYTES_PER_BLOCK - 1));
  assign drop      = blk_valid && fifo_full && !pop;
  // The outgoing byte always sits in the shift register's output lane, so tx_data is a flop output.
  assign tx_data   = MSB_FIRST ? shreg[127:120] : shreg[7:0];
  assign busy      = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) next_state = LOAD;
      LOAD: begin
        pop        = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        // A block arriving this cycle cannot be dropped here unless the FIFO is already non-empty.
        if (last_byte) next_state = (!fifo_empty || blk_valid) ? LOAD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      shreg    <= '0;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      tx_valid <= (next_state == SEND);
      if (state == LOAD) begin
        shreg    <= head;
        byte_cnt <= '0;
      end else if (state == SEND && fire) begin
        shreg    <= shift_byte(shreg, MSB_FIRST);
        byte_cnt <= byte_cnt + 4'd1;
      end
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_ctr_uart_serializer.sv
// Scoreboard bench: accepted blocks expand into an expected byte queue; a
// negedge monitor pops and compares on every handshake and checks stall stability.
module tb_aes_ctr_uart_serializer;
  import aes_uart_pkg::*;

  localparam int DEPTH     = 4;
  localparam bit MSB_FIRST = 1'b1;
  localparam int LW        = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          blk_valid;
  logic [127:0]  blk_data;
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          clear_overflow;

  aes_ctr_uart_serializer #(.DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk            (clk),
    .reset          (reset),
    .blk_valid      (blk_valid),
    .blk_data       (blk_data),
    .tx_ready       (tx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  byte_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    hs_count = 0;
  int    mode = 0;  // 0: ready high, 1: pattern 1,0,0,1, 2: random, 3: ready low

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a block becomes 16 bytes in wire order.
  function automatic void push_block(input block_t b);
    for (int i = 0; i < BYTES_PER_BLOCK; i++)
      exp_q.push_back(MSB_FIRST ? b[8*(15-i) +: 8] : b[8*i +: 8]);
  endfunction

  function automatic block_t rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // tx_ready driver
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pi = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = pat[pi];
          pi = (pi + 1) % 4;
        end
        2: tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  initial begin
    bit    stalled = 1'b0;
    byte_t held = '0;
    byte_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", tx_valid, 1);
          check("hold_data", tx_data, held);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte: got %0h expected none at %0t", tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("byte", tx_data, e);
          end
          hs_count++;
        end
        stalled = tx_valid && !tx_ready;
        held    = tx_data;
      end
    end
  end

  task automatic send_block(input block_t b, input bit accept);
    @(posedge clk);
    #1;
    blk_valid = 1'b1;
    blk_data  = b;
    if (accept) push_block(b);
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
  endtask

  // n back-to-back pulses; only the first n_accept are expected to survive
  task automatic send_seq(input int n, input int n_accept);
    block_t b;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      b = rand_block();
      blk_valid = 1'b1;
      blk_data  = b;
      if (i < n_accept) push_block(b);
      @(posedge clk);
      #1;
    end
    blk_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (hs_count < target) begin
      total++;
      bad++;
      $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_count, target);
    end
  endtask

  // Called right after send_block returns (cycle N+1 + #1).
  task automatic latency_check(input byte_t first);
    check("lat_level_n1", fifo_level, 1);
    check("lat_valid_n1", tx_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid_n2", tx_valid, 0);
    check("lat_busy_n2", busy, 1);
    @(posedge clk);
    #1;
    check("lat_valid_n3", tx_valid, 1);
    check("lat_data_n3", tx_data, first);
  endtask

  initial begin
    int hs0;
    block_t b;
    reset = 1'b0;
    blk_valid = 1'b0;
    blk_data = '0;
    clear_overflow = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Single block, ready high
    mode = 0;
    repeat (2) @(posedge clk);
    send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
    latency_check(8'h00);
    wait_drain(100);
    #1;
    check("single_busy_done", busy, 0);

    // Backpressure pattern
    mode = 1;
    hs0 = hs_count;
    send_block(rand_block(), 1'b1);
    wait_drain(500);
    check("bp_handshakes", hs_count - hs0, 16);
    mode = 0;
    repeat (3) @(posedge clk);

    // Burst of 6 with ready low: one popped, four stored, sixth dropped
    mode = 3;
    repeat (2) @(posedge clk);
    send_seq(6, 5);
    check("burst_level", fifo_level, DEPTH);
    check("burst_overflow", overflow, 1);
    check("burst_stall_valid", tx_valid, 1);
    // clear coinciding with a drop
    blk_valid = 1'b1;
    blk_data = rand_block();
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    clear_overflow = 1'b0;
    check("clear_vs_drop", overflow, 1);
    check("clear_vs_drop_level", fifo_level, DEPTH);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;
    check("clear_overflow", overflow, 0);
    hs0 = hs_count;
    mode = 0;
    wait_drain(300);
    check("burst_handshakes", hs_count - hs0, 80);
    repeat (3) @(posedge clk);

    // Full FIFO plus a write in the LOAD cycle
    hs0 = hs_count;
    send_block(rand_block(), 1'b1);
    send_seq(4, 4);
    wait_hs(hs0 + 16, 200);
    #1;
    check("fpp_level_load", fifo_level, DEPTH);
    check("fpp_gap_valid", tx_valid, 0);
    b = rand_block();
    blk_valid = 1'b1;
    blk_data = b;
    push_block(b);
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    check("fpp_level_after", fifo_level, DEPTH);
    check("fpp_overflow", overflow, 0);
    wait_drain(400);
    check("fpp_handshakes", hs_count - hs0, 96);
    repeat (3) @(posedge clk);

    // Reset after byte 5 of a block
    hs0 = hs_count;
    send_block(rand_block(), 1'b1);
    wait_hs(hs0 + 6, 100);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_block({16{8'hA5}}, 1'b1);
    latency_check(8'hA5);
    wait_drain(100);

    // Randomized traffic, throttled so the FIFO cannot overflow
    mode = 2;
    for (int k = 0; k < 24; k++) begin
      int n = 0;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      while ((exp_q.size() + 15) / 16 >= DEPTH && n < 500) begin
        @(posedge clk);
        n++;
      end
      send_block(rand_block(), 1'b1);
    end
    wait_drain(3000);
    check("rand_overflow", overflow, 0);
    mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
